// File: rtl/bt_uart_rx.sv
// bt_uart_rx: UART 8N1 receiver holding the last good byte; BT_CMD_FILTER_EN restricts accepted bytes to 8'hA1..8'hA8
module bt_uart_rx #(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 9600
) (
  input  logic       clk_100,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);
  localparam int BAUD_DIV = CLK_HZ / BAUD;
  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF_T = CW'(HALF_DIV - 1);
  localparam logic [CW-1:0] BAUD_T = CW'(BAUD_DIV - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  state_t state, state_n;
  logic rx_m, rx_s;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n, data_n;
  logic dv_n, fe_n, accept;
`ifdef BT_CMD_FILTER_EN
  assign accept = shift inside {[8'hA1:8'hA8]};
`else
  assign accept = 1'b1;
`endif
  assign busy = state != IDLE;
  always_ff @(posedge clk_100) begin
    if (rst) begin
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shift      <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_m       <= rx;
      rx_s       <= rx_m;
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      shift      <= shift_n;
      data       <= data_n;
      data_valid <= dv_n;
      frame_err  <= fe_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    shift_n = shift;
    data_n  = data;
    dv_n    = 1'b0;
    fe_n    = 1'b0;
    case (state)
      IDLE: begin
        cnt_n   = '0;
        state_n = rx_s ? IDLE : START;
      end
      START: if (cnt == HALF_T) begin
        cnt_n   = '0;
        idx_n   = '0;
        state_n = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt == BAUD_T) begin
        cnt_n          = '0;
        shift_n[idx]   = rx_s;
        idx_n          = idx + 3'd1;
        state_n        = idx == 3'd7 ? STOP : DATA;
      end
      STOP: if (cnt == BAUD_T) begin
        cnt_n   = '0;
        state_n = rx_s ? IDLE : BREAK;
        fe_n    = !rx_s;
        dv_n    = rx_s && accept;
        data_n  = rx_s && accept ? shift : data;
      end
      BREAK: begin
        cnt_n   = '0;
        state_n = rx_s ? IDLE : BREAK;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_bt_uart_rx.sv
// tb_bt_uart_rx: scoreboard bench for bt_uart_rx at 16 clocks per bit
module tb_bt_uart_rx;
  logic clk_100 = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b1;
  logic [7:0] data;
  logic data_valid, frame_err, busy;
  int n_chk = 0, n_pass = 0;
  int cyc = 0, dv_cyc = 0, dv_prev_cyc = 0, n_dv = 0, n_dv_exp = 0;
  int fe_pending = 0;
  logic dv_prev = 1'b0, fe_prev = 1'b0;
  logic [7:0] last_exp = 8'h00;
  logic [7:0] q[$];
  bt_uart_rx #(.CLK_HZ(1600000), .BAUD(100000)) dut (
    .clk_100(clk_100), .rst(rst), .rx(rx), .data(data),
    .data_valid(data_valid), .frame_err(frame_err), .busy(busy)
  );
  always #5 clk_100 = ~clk_100;
  always @(posedge clk_100) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
  endtask
  function automatic bit accepted(input logic [7:0] b);
`ifdef BT_CMD_FILTER_EN
    return b >= 8'hA1 && b <= 8'hA8;
`else
    return 1'b1;
`endif
  endfunction
  task automatic tick(input int n);
    repeat (n) @(posedge clk_100);
    #1;
  endtask
  task automatic send(input logic [7:0] b, input logic stop, input int abort);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    if (abort < 0) begin
      if (!stop) fe_pending++;
      else if (accepted(b)) begin
        q.push_back(b);
        last_exp = b;
        n_dv_exp++;
      end
    end
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      if (i == abort) begin
        tick(8);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        rx = 1'b1;
        last_exp = 8'h00;
        chk("abort_data", data, 8'h00);
        chk("abort_busy", busy, 1'b0);
        chk("abort_pulses", {data_valid, frame_err}, 2'b00);
        return;
      end
      tick(8);
      if (i == 5) chk("busy_frame", busy, 1'b1);
      tick(8);
    end
  endtask
  always @(negedge clk_100) begin
    if (data_valid) begin
      n_dv++;
      dv_prev_cyc = dv_cyc;
      dv_cyc = cyc;
      chk("dv_once", {dv_prev, frame_err}, 2'b00);
      chk("dv_pending", q.size() > 0, 1'b1);
      if (q.size() > 0) chk("dv_data", data, q.pop_front());
    end
    if (frame_err) begin
      chk("fe_once", {fe_prev, data_valid}, 2'b00);
      chk("fe_pending", fe_pending > 0, 1'b1);
      chk("fe_data", data, last_exp);
      if (fe_pending > 0) fe_pending--;
    end
    dv_prev = data_valid;
    fe_prev = frame_err;
  end
  initial begin
    int t0, k;
    tick(3);
    chk("rst_data", data, 8'h00);
    chk("rst_dv", data_valid, 1'b0);
    chk("rst_fe", frame_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    tick(5);
    t0 = cyc;
    send(8'hA2, 1'b1, -1);
    chk("latency_ok", (dv_cyc - t0 >= 153) && (dv_cyc - t0 <= 155), 1'b1);
    tick(500);
    chk("hold_a2", data, 8'hA2);
    send(8'hA5, 1'b1, -1);
    send(8'hA8, 1'b1, -1);
    tick(20);
    chk("b2b_gap", dv_cyc - dv_prev_cyc, 160);
    chk("b2b_data", data, 8'hA8);
    rx = 1'b0;
    tick(4);
    chk("glitch_busy", busy, 1'b1);
    rx = 1'b1;
    k = 0;
    while (busy && k < 20) begin
      tick(1);
      k++;
    end
    chk("glitch_idle", k <= 11, 1'b1);
    tick(20);
    chk("glitch_data", data, 8'hA8);
    send(8'hA1, 1'b0, -1);
    rx = 1'b0;
    tick(100);
    chk("break_busy", busy, 1'b1);
    chk("break_data", data, 8'hA8);
    rx = 1'b1;
    tick(4);
    chk("break_exit", busy, 1'b0);
    send(8'hA3, 1'b1, -1);
    tick(20);
    chk("after_fe", data, 8'hA3);
    send(8'h4F, 1'b1, -1);
    tick(20);
    chk("filter_data", data, last_exp);
    send(8'hA6, 1'b1, 4);
    tick(400);
    chk("abort_hold", data, 8'h00);
    send(8'hA7, 1'b1, -1);
    tick(50);
    chk("final_data", data, last_exp);
    chk("q_empty", q.size(), 0);
    chk("fe_left", fe_pending, 0);
    chk("dv_count", n_dv, n_dv_exp);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
